// File: rtl/buzzer_pkg.sv
// Shared types and register map for the buzzer tone generator.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TONE_ON  = 2'd1,
        TONE_OFF = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_HALF = 2'd0;
    localparam logic [1:0] ADDR_ON   = 2'd1;
    localparam logic [1:0] ADDR_OFF  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_PHASE_BIT = 1;
    localparam int CTRL_BUSY_BIT  = 2;

endpackage

// File: rtl/buzzer_half_div.sv
// Half-period counter: pulses tick on the last cycle of each half-period.
module buzzer_half_div #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] half,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt_reg;

    // ">=" rather than "==" so a HALF that shrinks below the count ends the half at once
    assign tick = !clr && (div_cnt_reg >= (half - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n || clr || tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Avalon-MM controlled square-wave buzzer driver with continuous and pulsed modes.
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int DIV_W        = 20,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 25000,
    parameter int DEFAULT_ON   = 100,
    parameter int DEFAULT_OFF  = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        buzzer_out,
    output logic        busy
);

    logic [DIV_W-1:0] half_reg;
    logic [CNT_W-1:0] on_reg;
    logic [CNT_W-1:0] off_reg;
    logic             mode_reg;

    state_t           state_reg, state_next;
    logic             buzzer_reg, buzzer_next;
    logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
    logic             off_phase_reg, off_phase_next;
    logic [CNT_W:0]   per_inc;
    logic             tick;
    logic             div_clr;
    logic             wr_en;
    logic             pulsed;
    logic             silent;
    logic             phase;
    logic             unused_writedata;

    assign wr_en            = chipselect && !write_n;
    assign pulsed           = mode_reg && (off_reg != '0);
    assign silent           = mode_reg && (on_reg == '0);
    assign div_clr          = (state_reg == IDLE) || !enable;
    assign unused_writedata = &{1'b0, writedata[31:DIV_W]};

    buzzer_half_div #(.DIV_W(DIV_W)) u_half_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (div_clr),
        .half    (half_reg),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            half_reg <= DIV_W'(DEFAULT_HALF);
            on_reg   <= CNT_W'(DEFAULT_ON);
            off_reg  <= CNT_W'(DEFAULT_OFF);
            mode_reg <= 1'b0;
        end else if (wr_en) begin
            case (address)
                ADDR_HALF: half_reg <= (writedata[DIV_W-1:0] == '0) ? DIV_W'(1)
                                                                    : writedata[DIV_W-1:0];
                ADDR_ON:   on_reg   <= writedata[CNT_W-1:0];
                ADDR_OFF:  off_reg  <= writedata[CNT_W-1:0];
                default:   mode_reg <= writedata[CTRL_MODE_BIT];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            buzzer_reg    <= 1'b0;
            per_cnt_reg   <= '0;
            off_phase_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            buzzer_reg    <= buzzer_next;
            per_cnt_reg   <= per_cnt_next;
            off_phase_reg <= off_phase_next;
        end
    end

    // Periods end on the high-to-low toggle in TONE_ON; in TONE_OFF on every second tick.
    always_comb begin
        state_next     = state_reg;
        buzzer_next    = buzzer_reg;
        per_cnt_next   = per_cnt_reg;
        off_phase_next = off_phase_reg;
        per_inc        = {1'b0, per_cnt_reg} + (CNT_W + 1)'(1);
        if (!enable) begin
            state_next     = IDLE;
            buzzer_next    = 1'b0;
            per_cnt_next   = '0;
            off_phase_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    per_cnt_next   = '0;
                    off_phase_next = 1'b0;
                    state_next     = silent ? TONE_OFF : TONE_ON;
                    buzzer_next    = !silent;
                end
                TONE_ON: begin
                    if (tick) begin
                        buzzer_next = !buzzer_reg;
                        if (buzzer_reg) begin
                            if (silent || (pulsed && per_inc == {1'b0, on_reg})) begin
                                state_next     = TONE_OFF;
                                per_cnt_next   = '0;
                                off_phase_next = 1'b0;
                            end else begin
                                per_cnt_next = per_inc[CNT_W-1:0];
                            end
                        end
                    end
                end
                TONE_OFF: begin
                    buzzer_next = 1'b0;
                    if (tick) begin
                        off_phase_next = !off_phase_reg;
                        if (off_phase_reg) begin
                            if (silent) begin
                                per_cnt_next = '0;
                            end else if (!pulsed || per_inc == {1'b0, off_reg}) begin
                                state_next     = TONE_ON;
                                buzzer_next    = 1'b1;
                                per_cnt_next   = '0;
                                off_phase_next = 1'b0;
                            end else begin
                                per_cnt_next = per_inc[CNT_W-1:0];
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_reg != IDLE);
        phase      = (state_reg == TONE_ON);
        buzzer_out = buzzer_reg;
        readdata   = '0;
        case (address)
            ADDR_HALF: readdata = 32'(half_reg);
            ADDR_ON:   readdata = 32'(on_reg);
            ADDR_OFF:  readdata = 32'(off_reg);
            default: begin
                readdata[CTRL_MODE_BIT]  = mode_reg;
                readdata[CTRL_PHASE_BIT] = phase;
                readdata[CTRL_BUSY_BIT]  = busy;
            end
        endcase
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Scoreboard bench: a waveform-formula model predicts each cycle, a monitor compares at negedge.
module tb_buzzer_tone_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        buzzer_out;
    logic        busy;

    buzzer_tone_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .buzzer_out (buzzer_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        buz;
        logic        bsy;
        logic [31:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   model_on = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("buzzer_out", 32'(buzzer_out), 32'(e.buz));
                check("busy", 32'(busy), 32'(e.bsy));
                if (e.chk_rd) check("readdata", readdata, e.rd);
            end
        end
    end

    // Reference model: output is a closed-form function of time since enable and the config.
    initial begin : model
        int   m_half, m_on, m_off, t, seg_on, len, tm;
        bit   m_mode, act;
        logic e_buz, e_ph;
        exp_t e;
        m_half = 25000; m_on = 100; m_off = 100; m_mode = 0; act = 0; t = 0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_half = 25000; m_on = 100; m_off = 100; m_mode = 0;
                act = 0; t = 0;
            end else begin
                if (chipselect && !write_n) begin
                    case (address)
                        2'd0: m_half = (writedata[19:0] == 0) ? 1 : int'(writedata[19:0]);
                        2'd1: m_on   = int'(writedata[15:0]);
                        2'd2: m_off  = int'(writedata[15:0]);
                        default: m_mode = writedata[0];
                    endcase
                end
                if (!enable) act = 0;
                else if (!act) begin act = 1; t = 0; end
                else t++;
            end
            e_buz = 0; e_ph = 0;
            if (act) begin
                if (m_mode && m_on == 0) begin
                    e_buz = 0; e_ph = 0;
                end else if (m_mode && m_off != 0) begin
                    seg_on = (2 * m_on - 1) * m_half;
                    len    = seg_on + 2 * m_off * m_half;
                    tm     = t % len;
                    if (tm < seg_on) begin
                        e_buz = ((tm / m_half) % 2 == 0);
                        e_ph  = 1;
                    end
                end else begin
                    e_buz = ((t / m_half) % 2 == 0);
                    e_ph  = 1;
                end
            end
            case (address)
                2'd0: e.rd = 32'(m_half);
                2'd1: e.rd = 32'(m_on);
                2'd2: e.rd = 32'(m_off);
                default: e.rd = {29'b0, act, e_ph, m_mode};
            endcase
            e.buz    = e_buz;
            e.bsy    = act;
            e.chk_rd = 1'b1;
            if (model_on) sb_q.push_back(e);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step();
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic cfg(input int h, input int on, input int off, input int mode);
        $display("cfg half=%0d on=%0d off=%0d mode=%0d", h, on, off, mode);
        wr(2'd0, 32'(h));
        wr(2'd1, 32'(on));
        wr(2'd2, 32'(off));
        wr(2'd3, 32'(mode));
        step();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            address = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic push_dir(input logic b, input logic s);
        exp_t e;
        e.buz = b; e.bsy = s; e.rd = '0; e.chk_rd = 1'b0;
        sb_q.push_back(e);
    endtask

    initial begin : stim
        reset_n = 1'b0; enable = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;

        $display("reset with concurrent write");
        step();
        wr(2'd0, 32'd7);
        step();
        reset_n = 1'b1; address = 2'd0;
        step(); address = 2'd1;
        step(); address = 2'd2;
        step(); address = 2'd3;

        $display("continuous tone half=4");
        cfg(4, 100, 100, 0);
        enable = 1'b1; address = 2'd3;
        run(20);
        step(); enable = 1'b0;

        $display("pulsed half=2 on=3 off=2");
        cfg(2, 3, 2, 1);
        enable = 1'b1;
        run(45);
        step(); enable = 1'b0;

        $display("mid-period disable and re-enable");
        cfg(4, 100, 100, 0);
        enable = 1'b1;
        run(2);
        step(); enable = 1'b0;
        step(); enable = 1'b1;
        run(10);
        step(); enable = 1'b0;

        $display("half write of zero");
        wr(2'd0, 32'd0);
        step(); address = 2'd0; enable = 1'b1;
        run(8);
        step(); enable = 1'b0;

        $display("half shrink 8 -> 3 mid-half");
        cfg(8, 100, 100, 0);
        step();
        model_on = 1'b0;
        enable   = 1'b1;
        push_dir(1'b1, 1'b1);
        for (int k = 0; k < 19; k++) begin
            step();
            if (k == 5) begin
                chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'd3;
            end
            push_dir(((k + 1) <= 6) ? 1'b1 : ((((k + 1 - 7) / 3) % 2) != 0), 1'b1);
        end
        step(); enable = 1'b0;
        push_dir(1'b0, 1'b0);
        step(); model_on = 1'b1;

        $display("silent pulsed on=0 then reset mid-pattern");
        cfg(3, 0, 100, 1);
        enable = 1'b1; address = 2'd3;
        run(12);
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1; address = 2'd3;
        run(5);
        step(); enable = 1'b0; address = 2'd0;
        step(); address = 2'd1;
        step(); address = 2'd2;

        for (int i = 0; i < 8; i++) begin
            cfg($urandom_range(0, 5), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 1));
            enable = 1'b1;
            run($urandom_range(30, 70));
            step(); enable = 1'b0;
            repeat ($urandom_range(1, 2)) step();
            enable = 1'b1;
            run(20);
            step(); enable = 1'b0;
            step();
        end

        step();
        step();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
